// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter fed from a FIFO read port with one-cycle registered read latency.
// Issues one read per frame; the bit period is latched per frame from baud_div.
//
// state | meaning
// IDLE  | line idle, waiting for enable and a non-empty FIFO
// REQ   | one-cycle FIFO read request
// WAIT  | FIFO output registered; load the byte or give up if it is not valid
// START | start bit
// DATA  | data bits, LSB first
// STOP  | stop bit; frame_done on its last cycle
module fifo_uart_tx #(
  parameter int fbits    = 8,
  parameter int div_bits = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [div_bits-1:0] baud_div,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [fbits-1:0]    fifo_data,
  input  logic                fifo_data_valid,
  output logic                fifo_rd,
  output logic                txd,
  output logic                busy,
  output logic                frame_done
);

  localparam int IDX_W = (fbits > 1) ? $clog2(fbits) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(fbits - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic                txd_q, txd_d;
  logic                frame_done_q, frame_done_d;
  logic [div_bits-1:0] timer_q, timer_d;
  logic [div_bits-1:0] div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [fbits-1:0]    shift_q, shift_d;
  logic                tc;

  assign tc = (timer_q == div_q);

  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    timer_d = timer_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (enable && !fifo_empty) state_d = S_REQ;
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (fifo_data_valid) begin
          shift_d = fifo_data;
          div_d   = baud_div;
          timer_d = '0;
          txd_d   = 1'b0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tc) begin
          timer_d = '0;
          txd_d   = shift_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tc) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            txd_d = shift_d[0];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tc) begin
          timer_d = '0;
          state_d = (enable && !fifo_empty) ? S_REQ : S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    // Registered pulse: high during the STOP cycle whose timer sits at terminal count.
    frame_done_d = (state_d == S_STOP) && (timer_d == div_d);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      txd_q        <= 1'b1;
      frame_done_q <= 1'b0;
      timer_q      <= '0;
      div_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
    end else begin
      state_q      <= state_d;
      txd_q        <= txd_d;
      frame_done_q <= frame_done_d;
      timer_q      <= timer_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
    end
  end

  assign fifo_rd    = (state_q == S_REQ);
  assign busy       = (state_q != S_IDLE);
  assign txd        = txd_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a behavioural FIFO with one-cycle read latency feeds
// the DUT, per-cycle outputs are logged, and frames are checked against hand-built waveforms.
module tb_fifo_uart_tx;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_data_valid = 1'b0;
  logic        fifo_rd, txd, busy, frame_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(.fbits(8), .div_bits(16)) dut (
    .clk(clk), .clr(clr), .baud_div(baud_div), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_data_valid(fifo_data_valid),
    .fifo_rd(fifo_rd), .txd(txd), .busy(busy), .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // FIFO model: a read seen in cycle N presents data/valid during cycle N+1.
  logic [7:0] fq[$];
  logic [7:0] hold = 8'h00;
  bit pending = 0, drop_next = 0, drop_hold = 0;

  always @(negedge clk) begin
    fifo_data_valid = pending && !drop_hold;
    fifo_data       = hold;
    pending         = fifo_rd;
    if (fifo_rd) begin
      drop_hold = drop_next;
      drop_next = 0;
      hold      = (fq.size() > 0) ? fq.pop_front() : 8'h00;
    end
    fifo_empty = (fq.size() == 0);
  end

  bit   rec = 0;
  logic txd_log[$], fd_log[$], rd_log[$], busy_log[$];

  always @(negedge clk) begin
    if (rec) begin
      txd_log.push_back(txd);
      fd_log.push_back(frame_done);
      rd_log.push_back(fifo_rd);
      busy_log.push_back(busy);
    end
  end

  task automatic clear_log();
    txd_log.delete(); fd_log.delete(); rd_log.delete(); busy_log.delete();
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 frame_done, 1 fifo_rd, 2 busy, 3 txd
  function automatic logic sig(input int which, input int j);
    if (j < 0 || j >= txd_log.size()) return 1'bx;
    case (which)
      0:       return fd_log[j];
      1:       return rd_log[j];
      2:       return busy_log[j];
      default: return txd_log[j];
    endcase
  endfunction

  function automatic int count_val(input int which, input logic v);
    int c = 0;
    for (int j = 0; j < txd_log.size(); j++) if (sig(which, j) === v) c++;
    return c;
  endfunction

  function automatic int find_first(input int which, input int from);
    for (int j = (from < 0 ? 0 : from); j < txd_log.size(); j++)
      if (sig(which, j) === 1'b1) return j;
    return -1;
  endfunction

  function automatic int find_fall(input int from);
    for (int j = (from < 0 ? 0 : from); j < txd_log.size(); j++)
      if (txd_log[j] === 1'b0 && (j == 0 || txd_log[j-1] === 1'b1)) return j;
    return -1;
  endfunction

  // Cycles in the frame starting at f (bit period p) whose txd differs from the 8N1 waveform.
  function automatic int wave_errs(input int f, input logic [7:0] b, input int p);
    int errs = 0;
    logic e;
    for (int s = 0; s < 10; s++) begin
      if (s == 0) e = 1'b0;
      else if (s == 9) e = 1'b1;
      else e = b[s-1];
      for (int k = 0; k < p; k++) if (sig(3, f + s*p + k) !== e) errs++;
    end
    return errs;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f, f1, f2, f3, r1, r2;
    bit seen;

    run(3);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    clr = 1'b0;
    enable = 1'b1;

    // Single byte 0xA5, 4 cycles/bit
    baud_div = 16'd3;
    clear_log(); rec = 1;
    fq.push_back(8'hA5);
    run(60); rec = 0;
    f = find_fall(0);
    check("t1_fall_found", (f >= 0), 1);
    check("t1_wave", wave_errs(f, 8'hA5, 4), 0);
    check("t1_done_pos", find_first(0, 0), f + 39);
    check("t1_done_cnt", count_val(0, 1'b1), 1);
    check("t1_rd_cnt", count_val(1, 1'b1), 1);
    check("t1_busy_after", sig(2, f + 40), 0);

    // Back-to-back 0x01,0x02,0x03, 1 cycle/bit
    baud_div = 16'd0;
    clear_log(); rec = 1;
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    run(60); rec = 0;
    f1 = find_fall(0);
    f2 = find_fall(f1 + 10);
    f3 = find_fall(f2 + 10);
    check("t2_gap12", f2 - f1, 12);
    check("t2_gap23", f3 - f2, 12);
    check("t2_wave1", wave_errs(f1, 8'h01, 1), 0);
    check("t2_wave2", wave_errs(f2, 8'h02, 1), 0);
    check("t2_wave3", wave_errs(f3, 8'h03, 1), 0);
    check("t2_rd_cnt", count_val(1, 1'b1), 3);
    check("t2_done_cnt", count_val(0, 1'b1), 3);

    // Empty FIFO with enable high
    clear_log(); rec = 1;
    run(100); rec = 0;
    check("t3_rd_cnt", count_val(1, 1'b1), 0);
    check("t3_txd_low", count_val(3, 1'b0), 0);
    check("t3_busy_cnt", count_val(2, 1'b1), 0);

    // Reset during DATA bit 3 of 0x5A, 3 cycles/bit
    baud_div = 16'd2;
    fq.push_back(8'h5A);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin seen = 1; break; end
    end
    check("t4_start_seen", seen, 1);
    run(9);
    check("t4_bit2", txd, 0);
    run(3);
    check("t4_bit3", txd, 1);
    clr = 1'b1;
    @(negedge clk);
    check("t4_clr_txd", txd, 1);
    check("t4_clr_busy", busy, 0);
    check("t4_clr_done", frame_done, 0);
    check("t4_clr_rd", fifo_rd, 0);
    clr = 1'b0;
    clear_log(); rec = 1;
    run(20); rec = 0;
    check("t4_post_rd", count_val(1, 1'b1), 0);
    check("t4_post_busy", count_val(2, 1'b1), 0);

    // Lost read: first read returns no valid data
    baud_div = 16'd0;
    drop_next = 1;
    clear_log(); rec = 1;
    fq.push_back(8'h3C); fq.push_back(8'h77);
    run(40); rec = 0;
    r1 = find_first(1, 0);
    r2 = find_first(1, r1 + 1);
    check("t5_rereq_gap", r2 - r1, 3);
    f = find_fall(0);
    check("t5_fall_after_rereq", (f > r2), 1);
    check("t5_wave", wave_errs(f, 8'h77, 1), 0);
    check("t5_rd_cnt", count_val(1, 1'b1), 2);
    check("t5_done_cnt", count_val(0, 1'b1), 1);

    // Enable drop and divider change mid-frame
    baud_div = 16'd3;
    clear_log(); rec = 1;
    fq.push_back(8'hC3); fq.push_back(8'h96);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin seen = 1; break; end
    end
    check("t6_start_seen", seen, 1);
    run(10);
    enable = 1'b0;
    baud_div = 16'd7;
    run(60);
    check("t6_rd_while_off", count_val(1, 1'b1), 1);
    enable = 1'b1;
    run(120); rec = 0;
    f1 = find_fall(0);
    f2 = find_fall(f1 + 40);
    check("t6_wave1", wave_errs(f1, 8'hC3, 4), 0);
    check("t6_done1_pos", find_first(0, 0), f1 + 39);
    check("t6_wave2", wave_errs(f2, 8'h96, 8), 0);
    check("t6_done2_pos", find_first(0, f1 + 40), f2 + 79);
    check("t6_rd_cnt", count_val(1, 1'b1), 2);
    check("t6_done_cnt", count_val(0, 1'b1), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
